// File: rtl/rv32i_types.sv
// Purpose : shared types and sizing for the ROB commit stage (head entry struct, FSM states).
// Latency : n/a (types and constants only).
// Backpres: n/a.
// Contents: WAY/NO_PHY_REGS/WIDTH/ROB sizing, DRAIN_CYCLES, rob_head_t, commit_state_t.
package rv32i_types;

  localparam int WAY          = 2;
  localparam int NO_PHY_REGS  = 64;
  localparam int WIDTH        = $clog2(NO_PHY_REGS);
  localparam int ROB_DEPTH    = 32;
  localparam int ROB_ID_WIDTH = $clog2(ROB_DEPTH);
  localparam int DRAIN_CYCLES = 2;
  localparam int ARCH_REGS    = 32;
  localparam int POP_W        = $clog2(WAY + 1);

  typedef struct packed {
    logic                    valid;
    logic                    done;
    logic [4:0]              rd_s;
    logic [WIDTH-1:0]        pd_s;
    logic [ROB_ID_WIDTH-1:0] rob_id;
    logic                    br_pred_valid;
    logic                    mispredict;
    logic [31:0]             target_pc;
  } rob_head_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2
  } commit_state_t;

endpackage

// File: rtl/rob_commit_stage_if.sv
// Purpose : bundles ROB head view, free-list return, RRAT export and redirect of the commit stage.
// Latency : n/a (wires only).
// Backpres: retire_stall tells the ROB to hold its head; rob_pop says how many entries left.
// Ports   : head_entry[WAY] (ROB->commit); rob_pop, free_push_en/pd, rrat_map, flush,
//           flush_pc, retire_stall, commit_count (commit->ROB/free list/front end).
interface rob_commit_stage_if;
  import rv32i_types::*;

  rob_head_t          head_entry   [WAY];
  logic [POP_W-1:0]   rob_pop;
  logic [WAY-1:0]     free_push_en;
  logic [WIDTH-1:0]   free_push_pd [WAY];
  logic [WIDTH-1:0]   rrat_map     [ARCH_REGS];
  logic               flush;
  logic [31:0]        flush_pc;
  logic               retire_stall;
  logic [31:0]        commit_count;

  // Commit stage side.
  modport master (
    input  head_entry,
    output rob_pop, free_push_en, free_push_pd, rrat_map,
           flush, flush_pc, retire_stall, commit_count
  );

  // ROB / free list / front-end side.
  modport slave (
    output head_entry,
    input  rob_pop, free_push_en, free_push_pd, rrat_map,
           flush, flush_pc, retire_stall, commit_count
  );

endinterface

// File: rtl/rrat_file.sv
// Purpose : retirement RAT, 32 x WIDTH map reset to identity, WAY write and WAY read ports.
// Latency : reads combinational from current state; writes visible after the clock edge.
// Backpres: none; every enabled write is taken.
// Ports   : clk, rst_n (sync, active low); wr_en/wr_idx/wr_pd[WAY]; rd_idx/rd_pd[WAY]; map[32].
module rrat_file
  import rv32i_types::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WAY-1:0]   wr_en,
  input  logic [4:0]       wr_idx [WAY],
  input  logic [WIDTH-1:0] wr_pd  [WAY],
  input  logic [4:0]       rd_idx [WAY],
  output logic [WIDTH-1:0] rd_pd  [WAY],
  output logic [WIDTH-1:0] map    [ARCH_REGS]
);

  logic [WIDTH-1:0] map_q [ARCH_REGS];
  logic [WIDTH-1:0] map_d [ARCH_REGS];

  // Ports are applied oldest first so the youngest slot wins on a shared index.
  always_comb begin
    map_d = map_q;
    for (int i = 0; i < WAY; i++) begin
      if (wr_en[i]) begin
        map_d[wr_idx[i]] = wr_pd[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < ARCH_REGS; r++) begin
        map_q[r] <= WIDTH'(r);
      end
    end else begin
      map_q <= map_d;
    end
  end

  always_comb begin
    for (int i = 0; i < WAY; i++) begin
      rd_pd[i] = map_q[rd_idx[i]];
    end
  end

  assign map = map_q;

endmodule

// File: rtl/rob_commit_stage.sv
// Purpose : in-order retirement of the completed head prefix, RRAT update, free-list return, flush.
// Latency : retire/pop/free combinational from head; RRAT, counter, flush registered (1 cycle).
// Backpres: retire_stall high in FLUSH/DRAIN, during which no head entry is consumed.
// Ports   : clk, rst_n (sync, active low); bus (rob_commit_stage_if.master).
module rob_commit_stage
  import rv32i_types::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  rob_commit_stage_if.master   bus
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  commit_state_t     state_q, state_d;
  logic              flush_q, flush_d;
  logic [31:0]       flush_pc_q, flush_pc_d;
  logic [CNT_W-1:0]  drain_q, drain_d;
  logic [31:0]       commit_count_q, commit_count_d;

  logic [WAY-1:0]    retire;
  logic [POP_W-1:0]  pop;
  logic              mis_hit;
  logic [31:0]       mis_pc;

  logic [WAY-1:0]    wr_en;
  logic [4:0]        rd_idx  [WAY];
  logic [WIDTH-1:0]  wr_pd   [WAY];
  logic [WIDTH-1:0]  old_pd  [WAY];
  logic [WIDTH-1:0]  free_pd [WAY];
  logic [WIDTH-1:0]  map     [ARCH_REGS];
  logic [WAY-1:0]    unused_head;

  // Retire prefix: slot 0 gates everything; a retiring mispredict blocks all younger slots.
  // rst_n is folded in so nothing pops or frees while reset is held.
  always_comb begin
    retire    = '0;
    retire[0] = rst_n & (state_q == RUN)
              & bus.head_entry[0].valid & bus.head_entry[0].done;
    for (int i = 1; i < WAY; i++) begin
      retire[i] = retire[i-1] & bus.head_entry[i].valid & bus.head_entry[i].done
                & ~bus.head_entry[i-1].mispredict;
    end
  end

  // Pop count, and the redirect target of the (at most one) retiring mispredict.
  always_comb begin
    pop     = '0;
    mis_hit = 1'b0;
    mis_pc  = '0;
    for (int i = 0; i < WAY; i++) begin
      pop = pop + POP_W'(retire[i]);
      if (retire[i] && bus.head_entry[i].mispredict) begin
        mis_hit = 1'b1;
        mis_pc  = bus.head_entry[i].target_pc;
      end
    end
  end

  // x0 never gets a mapping, so it neither writes the RRAT nor frees a register.
  always_comb begin
    for (int i = 0; i < WAY; i++) begin
      rd_idx[i] = bus.head_entry[i].rd_s;
      wr_pd[i]  = bus.head_entry[i].pd_s;
      wr_en[i]  = retire[i] & (bus.head_entry[i].rd_s != 5'd0);
    end
  end

  // Same-cycle bypass: the superseded register is the youngest older retiring writer of the
  // same rd, if any; otherwise the mapping currently held in the RRAT.
  always_comb begin
    for (int i = 0; i < WAY; i++) begin
      free_pd[i] = old_pd[i];
      for (int j = 0; j < i; j++) begin
        if (wr_en[j] && (bus.head_entry[j].rd_s == bus.head_entry[i].rd_s)) begin
          free_pd[i] = bus.head_entry[j].pd_s;
        end
      end
    end
  end

  // rob_id and br_pred_valid are carried for the ROB's benefit only.
  always_comb begin
    for (int i = 0; i < WAY; i++) begin
      unused_head[i] = ^{bus.head_entry[i].rob_id, bus.head_entry[i].br_pred_valid};
    end
  end

  rrat_file u_rrat (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (wr_en),
    .wr_idx (rd_idx),
    .wr_pd  (wr_pd),
    .rd_idx (rd_idx),
    .rd_pd  (old_pd),
    .map    (map)
  );

  // Next-state for the RUN -> FLUSH -> DRAIN sequence, counter and flush registers.
  always_comb begin
    state_d        = state_q;
    flush_d        = 1'b0;
    flush_pc_d     = flush_pc_q;
    drain_d        = drain_q;
    commit_count_d = commit_count_q + 32'(pop);
    unique case (state_q)
      RUN: begin
        if (mis_hit) begin
          state_d    = FLUSH;
          flush_d    = 1'b1;
          flush_pc_d = mis_pc;
        end
      end
      FLUSH: begin
        state_d = DRAIN;
        drain_d = CNT_W'(DRAIN_CYCLES - 1);
      end
      DRAIN: begin
        if (drain_q == '0) begin
          state_d = RUN;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= RUN;
      flush_q        <= 1'b0;
      flush_pc_q     <= '0;
      drain_q        <= '0;
      commit_count_q <= '0;
    end else begin
      state_q        <= state_d;
      flush_q        <= flush_d;
      flush_pc_q     <= flush_pc_d;
      drain_q        <= drain_d;
      commit_count_q <= commit_count_d;
    end
  end

  assign bus.rob_pop      = pop;
  assign bus.free_push_en = wr_en;
  assign bus.free_push_pd = free_pd;
  assign bus.rrat_map     = map;
  assign bus.flush        = flush_q;
  assign bus.flush_pc     = flush_pc_q;
  assign bus.retire_stall = (state_q != RUN);
  assign bus.commit_count = commit_count_q;

endmodule
